piano_voice_alloc: RTL
======================

# piano_voice_alloc

Polyphony controller for the FPGA piano: debounces the eight key switches and shares a fixed pool of tone-generator voices among them. Each held key is assigned at most one voice, and the block drives per-voice enable, key index and start strobe to the tone generators. It sits between the switch inputs and the LFSR/LUT tone datapath; the top level maps voice outputs to the GPIO banks.

## Interface
- NUM_KEYS, 8, number of key inputs (index width KW = clog2(NUM_KEYS))
- NUM_VOICES, 4, number of tone-generator voices
- DEBOUNCE_CYCLES, 50000, consecutive stable cycles required before a key change is accepted (≥2)
- AGE_W, 16, width of per-voice age counters
- clk  in  1  system clock, all logic on rising edge
- rst_n  in  1  asynchronous active-low reset
- sw  in  NUM_KEYS  raw key switches, asynchronous, 1 = pressed
- voice_active  out  NUM_VOICES  voice v is sounding
- voice_key  out  NUM_VOICES*KW  key index per voice, slice v = [v*KW +: KW]
- voice_start  out  NUM_VOICES  one-cycle pulse when voice v is (re)assigned; generator resets phase
- key_db  out  NUM_KEYS  debounced key state
- drop_cnt  out  8  saturating count of presses not granted a voice

## Operation
- Per key: 2-flop synchronizer, then debounce counter. key_db[k] takes the synced value only after it has differed from key_db[k] for DEBOUNCE_CYCLES consecutive cycles. Any bounce resets the counter.
- Scan pointer p cycles 0..NUM_KEYS-1, one key per clock, wrapping to 0.
- At key p: assigned = some active voice has voice_key == p.
  - key_db[p]=1, not assigned, muted[p]=0 → allocate the lowest-index inactive voice. Set voice_active, voice_key=p, age=0, and pulse voice_start.
  - key_db[p]=1, not assigned, no free voice → steal or drop (see Configuration).
  - key_db[p]=0, assigned → clear voice_active of that voice. Age is held.
  - key_db[p]=0 → clear muted[p].
  - All other cases: no action.
- Age: each active voice's age increments every cycle, saturating at 2^AGE_W−1.
- muted[k] is set when key k is dropped or stolen from. It blocks reallocation until key k is released, which prevents steal thrash and repeated drop counting.
- drop_cnt increments once per muted-by-drop event and saturates at 255.
- Reset: all outputs 0, p=0, muted=0, ages=0, debounce counters 0, sync flops 0.

## Timing
- Press to key_db: 2 sync cycles + DEBOUNCE_CYCLES.
- key_db to voice_active/voice_start: 1 to NUM_KEYS cycles, depending on scan position. voice_active, voice_key and voice_start update in the same cycle.
- Release to voice_active=0: same bound. No voice_start on release.
- A voice freed at scan step p can be allocated at step p+1.
- At most one allocation or release per cycle, so there are no simultaneous-event conflicts.
- rst_n assertion mid-operation clears everything immediately. After deassertion, keys held through reset are re-debounced before allocation.

## Configuration
- VOICE_STEAL_EN defined: a press with no free voice steals the voice with the largest age, ties broken by lowest index. The victim's old key gets muted=1. The voice is reassigned to p with age=0 and voice_start pulsed. drop_cnt is unchanged.
- VOICE_STEAL_EN undefined: the press is dropped. muted[p]=1 and drop_cnt increments. No age-compare logic is built, and age counters may be omitted.

## Structure
- Package piano_pkg holds the NUM_KEYS/NUM_VOICES defaults, the KW width constant, and the drop_cnt saturation limit.
- Sub-module key_debounce: one instance per key containing synchronizer and counter, parameterized by DEBOUNCE_CYCLES.
- Allocation, scan and age logic live in piano_voice_alloc.

## Test plan
All cases use NUM_VOICES=4 and DEBOUNCE_CYCLES=4.
- Reset with sw=8'hFF held: all outputs 0 during reset. After deassertion, key_db=8'hFF after 6 cycles, and voices 0..3 get keys 0..3 with 4 voice_start pulses.
- sw[5] bounces 1-0-1 every 2 cycles, then holds 1: key_db[5] rises only after 4 stable cycles, and exactly one voice_start occurs.
- Press key 2 then release: voice 0 becomes active with voice_key=2. After release debounce and scan, voice_active[0]=0 within 8 cycles.
- Hold keys 0–3, then press key 6, steal disabled: voice outputs are unchanged and drop_cnt=1 with no further increments while held. Release and re-press key 6 gives drop_cnt=2.
- Same stimulus with VOICE_STEAL_EN: the oldest voice (key 0's) switches to voice_key=6 with voice_start. Key 0 stays unassigned while held and is granted after release and re-press once a voice frees.
- Assert rst_n low while 3 voices are active: voice_active=0 and drop_cnt=0 asynchronously, before the next clk edge.

Source files
------------

// File: rtl/piano_voice_alloc_pkg.sv
// Shared constants for the piano polyphony controller: default key/voice counts,
// key-index width and the drop counter saturation helper.
package piano_pkg;

  localparam int NUM_KEYS_DEF        = 8;
  localparam int NUM_VOICES_DEF      = 4;
  localparam int DEBOUNCE_CYCLES_DEF = 50000;
  localparam int AGE_W_DEF           = 16;
  localparam int KW                  = $clog2(NUM_KEYS_DEF);

  localparam logic [7:0] DROP_MAX = 8'd255;

  function automatic logic [7:0] satInc8(input logic [7:0] value);
    logic [7:0] result;
    if (value == DROP_MAX) begin
      result = value;
    end else begin
      result = value + 8'd1;
    end
    return result;
  endfunction

endpackage

// File: rtl/piano_voice_alloc_debounce.sv
// One key input: two-flop synchronizer followed by a stability counter that only
// lets the debounced level follow after DEBOUNCE_CYCLES consecutive differing cycles.
module key_debounce #(
  parameter int DEBOUNCE_CYCLES = 50000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic sw,
  output logic key
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES);

  logic          sync1_r;
  logic          sync2_r;
  logic          db_r;
  logic [CW-1:0] cnt_r;

  // synchronize the raw switch and qualify any level change by its stable duration
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
      db_r    <= 1'b0;
      cnt_r   <= '0;
    end else begin
      sync1_r <= sw;
      sync2_r <= sync1_r;
      if (sync2_r != db_r) begin
        if (cnt_r == CW'(DEBOUNCE_CYCLES - 1)) begin
          db_r  <= sync2_r;
          cnt_r <= '0;
        end else begin
          cnt_r <= cnt_r + CW'(1);
        end
      end else begin
        cnt_r <= '0;
      end
    end
  end

  assign key = db_r;

endmodule

// File: rtl/piano_voice_alloc.sv
// Voice allocator: scans debounced keys one per clock and assigns tone-generator voices.
// Optional feature macro VOICE_STEAL_EN: steal the oldest voice instead of dropping the press.
module piano_voice_alloc
  import piano_pkg::*;
#(
  parameter int NUM_KEYS        = NUM_KEYS_DEF,
  parameter int NUM_VOICES      = NUM_VOICES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
  parameter int AGE_W           = AGE_W_DEF
) (
  input  logic                                   clk,
  input  logic                                   rst_n,
  input  logic [NUM_KEYS-1:0]                    sw,
  output logic [NUM_VOICES-1:0]                  voice_active,
  output logic [NUM_VOICES*$clog2(NUM_KEYS)-1:0] voice_key,
  output logic [NUM_VOICES-1:0]                  voice_start,
  output logic [NUM_KEYS-1:0]                    key_db,
  output logic [7:0]                             drop_cnt
);

  localparam int KEY_W = $clog2(NUM_KEYS);
  localparam int VW    = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  logic [NUM_KEYS-1:0]   keyDb_s;
  logic [KEY_W-1:0]      scanPtr_r;
  logic [NUM_KEYS-1:0]   muted_r;
  logic [7:0]            dropCnt_r;
  logic [NUM_VOICES-1:0] active_r;
  logic [NUM_VOICES-1:0] start_r;
  logic [KEY_W-1:0]      voiceKey_r [NUM_VOICES];

  logic          assignedHit_s;
  logic [VW-1:0] assignedIdx_s;
  logic          freeHit_s;
  logic [VW-1:0] freeIdx_s;
  logic          doGrant_s;
  logic [VW-1:0] grantIdx_s;
  logic          doDrop_s;
  logic          doRelease_s;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    key_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db (
      .clk   (clk),
      .rst_n (rst_n),
      .sw    (sw[k]),
      .key   (keyDb_s[k])
    );
  end

`ifdef VOICE_STEAL_EN
  logic [AGE_W-1:0] age_r [NUM_VOICES];
  logic [VW-1:0]    oldestIdx_s;
  logic [AGE_W-1:0] oldestAge_s;

  // oldest voice; strict compare keeps the lowest index on ties
  always_comb begin
    oldestIdx_s = '0;
    oldestAge_s = age_r[0];
    for (int v = 1; v < NUM_VOICES; v++) begin
      if (age_r[v] > oldestAge_s) begin
        oldestIdx_s = VW'(v);
        oldestAge_s = age_r[v];
      end else begin
        oldestIdx_s = oldestIdx_s;
      end
    end
  end

  // per-voice age: cleared on (re)assignment, otherwise saturating count while sounding
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int v = 0; v < NUM_VOICES; v++) age_r[v] <= '0;
    end else begin
      for (int v = 0; v < NUM_VOICES; v++) begin
        if (doGrant_s && (grantIdx_s == VW'(v))) begin
          age_r[v] <= '0;
        end else if (active_r[v] && (age_r[v] != '1)) begin
          age_r[v] <= age_r[v] + AGE_W'(1);
        end
      end
    end
  end
`endif

  // lookup for the scanned key: its current voice, and the lowest free voice
  always_comb begin
    assignedHit_s = 1'b0;
    assignedIdx_s = '0;
    freeHit_s     = 1'b0;
    freeIdx_s     = '0;
    for (int v = NUM_VOICES - 1; v >= 0; v--) begin
      if (!active_r[v]) begin
        freeHit_s = 1'b1;
        freeIdx_s = VW'(v);
      end else if (voiceKey_r[v] == scanPtr_r) begin
        assignedHit_s = 1'b1;
        assignedIdx_s = VW'(v);
      end else begin
        freeHit_s = freeHit_s;
      end
    end
  end

  // decide the single action for the scanned key this cycle
  always_comb begin
    doGrant_s   = 1'b0;
    doDrop_s    = 1'b0;
    doRelease_s = 1'b0;
    grantIdx_s  = freeIdx_s;
    if (keyDb_s[scanPtr_r]) begin
      if (!assignedHit_s && !muted_r[scanPtr_r]) begin
        if (freeHit_s) begin
          doGrant_s = 1'b1;
        end else begin
`ifdef VOICE_STEAL_EN
          doGrant_s  = 1'b1;
          grantIdx_s = oldestIdx_s;
`else
          doDrop_s   = 1'b1;
`endif
        end
      end else begin
        doGrant_s = 1'b0;
      end
    end else begin
      doRelease_s = assignedHit_s;
    end
  end

  // scan pointer, voice state, mute flags and drop counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      scanPtr_r <= '0;
      muted_r   <= '0;
      dropCnt_r <= 8'd0;
      active_r  <= '0;
      start_r   <= '0;
      for (int v = 0; v < NUM_VOICES; v++) voiceKey_r[v] <= '0;
    end else begin
      if (scanPtr_r == KEY_W'(NUM_KEYS - 1)) begin
        scanPtr_r <= '0;
      end else begin
        scanPtr_r <= scanPtr_r + KEY_W'(1);
      end
      start_r <= '0;
      if (doGrant_s) begin
        active_r[grantIdx_s]   <= 1'b1;
        voiceKey_r[grantIdx_s] <= scanPtr_r;
        start_r[grantIdx_s]    <= 1'b1;
`ifdef VOICE_STEAL_EN
        // the displaced key must be released before it can sound again
        if (!freeHit_s) muted_r[voiceKey_r[grantIdx_s]] <= 1'b1;
`endif
      end
      if (doDrop_s) begin
        muted_r[scanPtr_r] <= 1'b1;
        dropCnt_r          <= satInc8(dropCnt_r);
      end
      if (!keyDb_s[scanPtr_r]) muted_r[scanPtr_r] <= 1'b0;
      if (doRelease_s) active_r[assignedIdx_s] <= 1'b0;
    end
  end

  for (genvar v = 0; v < NUM_VOICES; v++) begin : g_voice
    assign voice_key[v*KEY_W +: KEY_W] = voiceKey_r[v];
  end

  assign voice_active = active_r;
  assign voice_start  = start_r;
  assign key_db       = keyDb_s;
  assign drop_cnt     = dropCnt_r;

endmodule
